// File: rtl/glm_dot_seq_pkg.sv
// Shared types and instruction-register field map for the glm_dot minibatch sequencer.
package glm_dot_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } t_seqstate;

    localparam int CTRL_REG     = 3;
    localparam int OFFS_REG     = 4;
    localparam int COUNT_REG    = 5;
    localparam int STRIDE_REG   = 6;
    localparam int FORWARD_BIT  = 16;
    localparam int SUBTRACT_BIT = 17;

    // Builds an engine control word from its fields.
    function automatic logic [31:0] ctrl_word(input logic [15:0] lines,
                                              input logic        forward,
                                              input logic        subtract);
        logic [31:0] w;
        w               = '0;
        w[15:0]         = lines;
        w[FORWARD_BIT]  = forward;
        w[SUBTRACT_BIT] = subtract;
        return w;
    endfunction

endpackage

// File: rtl/glm_credit_counter.sv
// Saturating credit counter tracking free entries in the downstream dot-result FIFO.
module glm_credit_counter
    import glm_dot_seq_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic clk,
    input  logic reset,
    input  logic take,
    input  logic give,
    output logic has_credit
);

    localparam int W = $clog2(DEPTH + 1);

    logic [W-1:0] credits;
    logic         give_eff;

    // A pop reported while the FIFO is already empty is spurious and dropped.
    assign give_eff   = give && (credits != W'(DEPTH));
    assign has_credit = (credits != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            credits <= W'(DEPTH);
        end else if (take && !give_eff) begin
            credits <= credits - W'(1);
        end else if (give_eff && !take) begin
            credits <= credits + W'(1);
        end
    end

endmodule

// File: rtl/glm_dot_sequencer.sv
// Runs the glm_dot engine once per minibatch sample, gated by result-FIFO credits.
// Optional GLM_DOT_SEQ_PERF_EN adds stall_cycles/active_cycles performance counters.
//
// state | meaning
// IDLE  | waiting for op_start
// ISSUE | holding for a FIFO credit, then launching one dot operation
// WAIT  | waiting for the engine's dot_done
// DONE  | emitting the op_done pulse
module glm_dot_sequencer
    import glm_dot_seq_pkg::*;
#(
    parameter int NUM_REGS       = 16,
    parameter int DOT_FIFO_DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     op_start,
    output logic                     op_done,
    input  logic [NUM_REGS-1:0][31:0] regs,
    output logic                     dot_start,
    output logic [31:0]              dot_cfg_ctrl,
    output logic [31:0]              dot_cfg_offs,
    input  logic                     dot_done,
    input  logic                     result_consumed,
    output logic                     busy,
`ifdef GLM_DOT_SEQ_PERF_EN
    output logic [31:0]              stall_cycles,
    output logic [31:0]              active_cycles,
`endif
    output logic [15:0]              samples_done
);

    t_seqstate   state;
    logic [31:0] ctrl;
    logic [15:0] model_off;
    logic [15:0] label_off;
    logic [15:0] num_samples;
    logic [15:0] model_stride;
    logic [15:0] label_stride;
    logic        has_credit;
    logic        issue;
    logic        accept;
    logic        unused_regs;

    assign unused_regs = ^regs;
    assign accept      = (state == IDLE) && op_start;
    assign issue       = (state == ISSUE) && has_credit;

    glm_credit_counter #(
        .DEPTH(DOT_FIFO_DEPTH)
    ) u_credit (
        .clk       (clk),
        .reset     (reset),
        .take      (issue),
        .give      (result_consumed),
        .has_credit(has_credit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            op_done      <= 1'b0;
            dot_start    <= 1'b0;
            busy         <= 1'b0;
            samples_done <= '0;
            dot_cfg_ctrl <= '0;
            dot_cfg_offs <= '0;
            ctrl         <= '0;
            model_off    <= '0;
            label_off    <= '0;
            num_samples  <= '0;
            model_stride <= '0;
            label_stride <= '0;
        end else begin
            op_done   <= 1'b0;
            dot_start <= 1'b0;
            case (state)
                IDLE: begin
                    // busy lingers through the op_done cycle so it covers the whole op.
                    busy <= 1'b0;
                    if (op_start) begin
                        busy         <= 1'b1;
                        ctrl         <= regs[CTRL_REG];
                        model_off    <= regs[OFFS_REG][15:0];
                        label_off    <= regs[OFFS_REG][31:16];
                        num_samples  <= regs[COUNT_REG][15:0];
                        label_stride <= regs[STRIDE_REG][15:0];
                        model_stride <= regs[STRIDE_REG][31:16];
                        samples_done <= '0;
                        state        <= (regs[COUNT_REG][15:0] == 16'd0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (has_credit) begin
                        dot_start    <= 1'b1;
                        dot_cfg_ctrl <= ctrl;
                        dot_cfg_offs <= {label_off, model_off};
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (dot_done) begin
                        samples_done <= samples_done + 16'd1;
                        model_off    <= model_off + model_stride;
                        label_off    <= label_off + label_stride;
                        state        <= (samples_done + 16'd1 == num_samples) ? DONE : ISSUE;
                    end
                end
                DONE: begin
                    op_done <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GLM_DOT_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles  <= '0;
            active_cycles <= '0;
        end else if (accept) begin
            stall_cycles  <= '0;
            active_cycles <= '0;
        end else begin
            if (busy) begin
                active_cycles <= active_cycles + 32'd1;
            end
            if ((state == ISSUE) && !has_credit) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_glm_dot_sequencer.sv
// Self-checking bench: a default-depth instance (index 0) and a depth-2 instance (index 1).
module tb_glm_dot_sequencer;
    import glm_dot_seq_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        op_start;
    logic [1:0]        dot_done;
    logic [1:0]        result_consumed;
    logic [15:0][31:0] regs;
    wire  [1:0]        op_done;
    wire  [1:0]        dot_start;
    wire  [1:0]        busy;
    wire  [31:0]       dot_cfg_ctrl [2];
    wire  [31:0]       dot_cfg_offs [2];
    wire  [15:0]       samples_done [2];
`ifdef GLM_DOT_SEQ_PERF_EN
    wire  [31:0]       stall_cycles  [2];
    wire  [31:0]       active_cycles [2];
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    glm_dot_sequencer #(.NUM_REGS(16), .DOT_FIFO_DEPTH(512)) dut_big (
        .clk(clk), .reset(reset), .op_start(op_start[0]), .op_done(op_done[0]),
        .regs(regs), .dot_start(dot_start[0]), .dot_cfg_ctrl(dot_cfg_ctrl[0]),
        .dot_cfg_offs(dot_cfg_offs[0]), .dot_done(dot_done[0]),
        .result_consumed(result_consumed[0]), .busy(busy[0]),
`ifdef GLM_DOT_SEQ_PERF_EN
        .stall_cycles(stall_cycles[0]), .active_cycles(active_cycles[0]),
`endif
        .samples_done(samples_done[0])
    );

    glm_dot_sequencer #(.NUM_REGS(16), .DOT_FIFO_DEPTH(2)) dut_small (
        .clk(clk), .reset(reset), .op_start(op_start[1]), .op_done(op_done[1]),
        .regs(regs), .dot_start(dot_start[1]), .dot_cfg_ctrl(dot_cfg_ctrl[1]),
        .dot_cfg_offs(dot_cfg_offs[1]), .dot_done(dot_done[1]),
        .result_consumed(result_consumed[1]), .busy(busy[1]),
`ifdef GLM_DOT_SEQ_PERF_EN
        .stall_cycles(stall_cycles[1]), .active_cycles(active_cycles[1]),
`endif
        .samples_done(samples_done[1])
    );

    // Reference: sample i sees base offsets advanced i times by the strides, mod 2^16.
    function automatic logic [31:0] exp_offs(input logic [31:0] base, input logic [31:0] stride,
                                             input int i);
        logic [15:0] m;
        logic [15:0] l;
        m = base[15:0]  + 16'(i) * stride[31:16];
        l = base[31:16] + 16'(i) * stride[15:0];
        return {l, m};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_op(input int s);
        op_start[s] = 1'b1;
        tick();
        op_start[s] = 1'b0;
    endtask

    task automatic pulse_rc(input int s);
        result_consumed[s] = 1'b1;
        tick();
        result_consumed[s] = 1'b0;
    endtask

    // Cycles until dot_start is seen (1 = now), -1 if not within budget.
    task automatic wait_start(input int s, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            if (dot_start[s] === 1'b1) begin
                n = k;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_op_done(input int s, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            if (op_done[s] === 1'b1) begin
                n = k;
                break;
            end
            tick();
        end
    endtask

    // Engine model: answer lat cycles after the dot_start cycle we are in.
    task automatic do_done(input int s, input int lat);
        repeat (lat) tick();
        dot_done[s] = 1'b1;
        tick();
        dot_done[s] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op_start = '0; dot_done = '0; result_consumed = '0; regs = '0;
        repeat (3) tick();
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if ({op_done[s], dot_start[s], busy[s]} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_flags dut%0d: got %b expected 000", s, {op_done[s], dot_start[s], busy[s]});
            end
            vectors++;
            if ({dot_cfg_ctrl[s], dot_cfg_offs[s], samples_done[s]} !== 80'd0) begin
                miscompares++;
                $display("FAIL reset_values dut%0d: ctrl %h offs %h samples %0d expected zero",
                         s, dot_cfg_ctrl[s], dot_cfg_offs[s], samples_done[s]);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp_tab [3] = '{32'h00200010, 32'h00220011, 32'h00240012};
        int g;
        regs[3] = 32'h00000004; regs[4] = 32'h00200010; regs[5] = 32'd3; regs[6] = 32'h00010002;
        start_op(0);
        for (int i = 0; i < 3; i++) begin
            wait_start(0, 40, g);
            vectors++;
            if (g !== 2) begin miscompares++; $display("FAIL basic_gap[%0d]: got %0d expected 2", i, g); end
            vectors++;
            if (dot_cfg_offs[0] !== exp_tab[i]) begin
                miscompares++; $display("FAIL basic_offs[%0d]: got %h expected %h", i, dot_cfg_offs[0], exp_tab[i]);
            end
            vectors++;
            if (dot_cfg_ctrl[0] !== 32'h4) begin
                miscompares++; $display("FAIL basic_ctrl[%0d]: got %h expected 4", i, dot_cfg_ctrl[0]);
            end
            do_done(0, 10);
        end
        wait_op_done(0, 40, g);
        vectors++;
        if (g !== 2) begin miscompares++; $display("FAIL basic_op_done_gap: got %0d expected 2", g); end
        vectors++;
        if (samples_done[0] !== 16'd3) begin
            miscompares++; $display("FAIL basic_samples: got %0d expected 3", samples_done[0]);
        end
        tick();
        vectors++;
        if ({op_done[0], busy[0]} !== 2'b00) begin
            miscompares++; $display("FAIL basic_after_done: op_done/busy got %b expected 00", {op_done[0], busy[0]});
        end
    endtask

    task automatic test_zero_samples();
        int busy_n = 0, starts = 0, g = -1;
        regs[5] = 32'hABCD0000;
        start_op(0);
        for (int k = 1; k <= 10; k++) begin
            if (busy[0] === 1'b1) busy_n++;
            if (dot_start[0] === 1'b1) starts++;
            if (op_done[0] === 1'b1 && g < 0) g = k;
            tick();
        end
        vectors++;
        if (g !== 2) begin miscompares++; $display("FAIL zero_op_done_gap: got %0d expected 2", g); end
        vectors++;
        if (busy_n !== 2) begin miscompares++; $display("FAIL zero_busy_cycles: got %0d expected 2", busy_n); end
        vectors++;
        if (starts !== 0) begin miscompares++; $display("FAIL zero_dot_starts: got %0d expected 0", starts); end
        vectors++;
        if (samples_done[0] !== 16'd0) begin
            miscompares++; $display("FAIL zero_samples: got %0d expected 0", samples_done[0]);
        end
    endtask

    task automatic test_spurious();
        logic [31:0] base = 32'h1234_0F00, stride = 32'h0100_0003;
        logic [15:0] prev;
        int g;
        regs[3] = 32'h0002_0007; regs[4] = base; regs[5] = 32'd2; regs[6] = stride;
        prev = samples_done[0];
        dot_done[0] = 1'b1; tick(); dot_done[0] = 1'b0;
        tick();
        vectors++;
        if (samples_done[0] !== prev) begin
            miscompares++; $display("FAIL spurious_idle_done: got %0d expected %0d", samples_done[0], prev);
        end
        start_op(0);
        regs[4] = ~base; regs[5] = 32'd7;
        op_start[0] = 1'b1; dot_done[0] = 1'b1;
        tick();
        op_start[0] = 1'b0; dot_done[0] = 1'b0;
        vectors++;
        if (dot_start[0] !== 1'b1 || dot_cfg_offs[0] !== base) begin
            miscompares++; $display("FAIL spurious_first_issue: start %b offs %h expected 1 %h", dot_start[0], dot_cfg_offs[0], base);
        end
        start_op(0);
        do_done(0, 3);
        wait_start(0, 40, g);
        vectors++;
        if (g !== 2 || dot_cfg_offs[0] !== exp_offs(base, stride, 1)) begin
            miscompares++; $display("FAIL spurious_second_issue: gap %0d offs %h expected 2 %h", g, dot_cfg_offs[0], exp_offs(base, stride, 1));
        end
        do_done(0, 2);
        wait_op_done(0, 40, g);
        vectors++;
        if (g !== 2 || samples_done[0] !== 16'd2) begin
            miscompares++; $display("FAIL spurious_finish: gap %0d samples %0d expected 2 2", g, samples_done[0]);
        end
    endtask

    task automatic test_credit_stall();
        int g;
        regs[3] = 32'h1; regs[4] = 32'h0; regs[5] = 32'd4; regs[6] = 32'h0001_0001;
        start_op(1);
        for (int i = 0; i < 2; i++) begin
            wait_start(1, 40, g);
            vectors++;
            if (g !== 2) begin miscompares++; $display("FAIL stall_issue_gap[%0d]: got %0d expected 2", i, g); end
            do_done(1, 4);
        end
        for (int i = 2; i < 4; i++) begin
            wait_start(1, 15, g);
            vectors++;
            if (g !== -1) begin miscompares++; $display("FAIL stall_no_credit[%0d]: issued after %0d cycles, expected stall", i, g); end
            pulse_rc(1);
            wait_start(1, 40, g);
            vectors++;
            if (g !== 2 || dot_cfg_offs[1] !== exp_offs(32'h0, 32'h0001_0001, i)) begin
                miscompares++; $display("FAIL stall_resume[%0d]: gap %0d offs %h expected 2 %h", i, g, dot_cfg_offs[1], exp_offs(32'h0, 32'h0001_0001, i));
            end
            do_done(1, 4);
        end
        wait_op_done(1, 40, g);
        vectors++;
        if (g !== 2 || samples_done[1] !== 16'd4) begin
            miscompares++; $display("FAIL stall_finish: gap %0d samples %0d expected 2 4", g, samples_done[1]);
        end
    endtask

    // Credits start at 0 here; three pops should saturate at 2.
    task automatic test_coincident();
        int g;
        repeat (3) pulse_rc(1);
        regs[5] = 32'd3;
        start_op(1);
        wait_start(1, 40, g);
        vectors++;
        if (g !== 2) begin miscompares++; $display("FAIL coinc_first_gap: got %0d expected 2", g); end
        do_done(1, 3);
        pulse_rc(1);
        wait_start(1, 40, g);
        vectors++;
        if (g !== 1) begin miscompares++; $display("FAIL coinc_second_gap: got %0d expected 1", g); end
        do_done(1, 3);
        wait_start(1, 40, g);
        vectors++;
        if (g !== 2) begin miscompares++; $display("FAIL coinc_third_gap: got %0d expected 2", g); end
        do_done(1, 3);
        wait_op_done(1, 40, g);
        vectors++;
        if (g !== 2) begin miscompares++; $display("FAIL coinc_op_done_gap: got %0d expected 2", g); end
    endtask

    task automatic test_saturation();
        int g;
        regs[5] = 32'd1;
        start_op(1);
        wait_start(1, 15, g);
        vectors++;
        if (g !== -1) begin miscompares++; $display("FAIL sat_no_credit: issued after %0d cycles, expected stall", g); end
        pulse_rc(1);
        wait_start(1, 40, g);
        vectors++;
        if (g !== 2) begin miscompares++; $display("FAIL sat_resume_gap: got %0d expected 2", g); end
        do_done(1, 2);
        wait_op_done(1, 40, g);
    endtask

    task automatic test_reset_mid();
        int g;
        regs[3] = 32'h5; regs[4] = 32'h0040_0080; regs[5] = 32'd5; regs[6] = 32'h0002_0004;
        start_op(0);
        wait_start(0, 40, g);
        repeat (3) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if ({busy[s], dot_start[s], samples_done[s], dot_cfg_offs[s]} !== 50'd0) begin
                miscompares++; $display("FAIL midreset_state dut%0d: busy %b start %b samples %0d offs %h expected zero",
                                        s, busy[s], dot_start[s], samples_done[s], dot_cfg_offs[s]);
            end
        end
        regs[5] = 32'd2;
        start_op(1);
        for (int i = 0; i < 2; i++) begin
            wait_start(1, 40, g);
            vectors++;
            if (g !== 2) begin miscompares++; $display("FAIL midreset_credit_gap[%0d]: got %0d expected 2", i, g); end
            do_done(1, 2);
        end
        wait_op_done(1, 40, g);
        regs[4] = 32'h7777_1111; regs[5] = 32'd1;
        start_op(0);
        wait_start(0, 40, g);
        vectors++;
        if (g !== 2 || dot_cfg_offs[0] !== 32'h7777_1111) begin
            miscompares++; $display("FAIL midreset_restart: gap %0d offs %h expected 2 77771111", g, dot_cfg_offs[0]);
        end
        do_done(0, 5);
        wait_op_done(0, 40, g);
        vectors++;
        if (g !== 2 || samples_done[0] !== 16'd1) begin
            miscompares++; $display("FAIL midreset_finish: gap %0d samples %0d expected 2 1", g, samples_done[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] base, stride, ctrl;
        int n, g, lat;
        for (int b = 0; b < 8; b++) begin
            n      = $urandom_range(1, 5);
            base   = $urandom;
            stride = $urandom;
            ctrl   = ctrl_word(16'($urandom), 1'($urandom), 1'($urandom));
            regs[3] = ctrl; regs[4] = base; regs[6] = stride;
            regs[5] = {16'($urandom), 16'(n)};
            start_op(0);
            for (int i = 0; i < n; i++) begin
                wait_start(0, 40, g);
                vectors++;
                if (g !== 2) begin miscompares++; $display("FAIL rand_gap[%0d.%0d]: got %0d expected 2", b, i, g); end
                vectors++;
                if (dot_cfg_offs[0] !== exp_offs(base, stride, i) || dot_cfg_ctrl[0] !== ctrl) begin
                    miscompares++; $display("FAIL rand_cfg[%0d.%0d]: offs %h ctrl %h expected %h %h", b, i,
                                            dot_cfg_offs[0], dot_cfg_ctrl[0], exp_offs(base, stride, i), ctrl);
                end
                lat = $urandom_range(1, 8);
                do_done(0, lat);
                vectors++;
                if (dot_cfg_offs[0] !== exp_offs(base, stride, i)) begin
                    miscompares++; $display("FAIL rand_cfg_hold[%0d.%0d]: got %h expected %h", b, i, dot_cfg_offs[0], exp_offs(base, stride, i));
                end
            end
            wait_op_done(0, 40, g);
            vectors++;
            if (g !== 2 || samples_done[0] !== 16'(n)) begin
                miscompares++; $display("FAIL rand_finish[%0d]: gap %0d samples %0d expected 2 %0d", b, g, samples_done[0], n);
            end
            repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_samples();
        test_spurious();
        test_credit_stall();
        test_coincident();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/glm_dot_sequencer.md
Name: glm_dot_sequencer

Overview:
- Controller that runs one glm_dot-style dot engine over a minibatch of samples.
- On a single op_start it issues one dot operation per sample:
  - sets the engine configuration for that sample;
  - waits for the engine's completion;
  - advances model and label BRAM offsets by programmed strides.
- Holds a credit counter on the downstream dot-result FIFO so that no result is ever written into a full FIFO.
- Sits between the instruction dispatcher (regs/op_start/op_done) and the dot engine.

Parameters:
- NUM_REGS, 16, number of 32-bit instruction registers presented on regs.
- DOT_FIFO_DEPTH, 512, capacity of the result FIFO in entries; this is the initial credit count.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- op_start  input  1  one-cycle pulse; start minibatch
- op_done  output  1  one-cycle pulse; minibatch finished
- regs  input  32 x NUM_REGS  instruction registers, sampled only on accepted op_start
- dot_start  output  1  one-cycle pulse to the dot engine's op_start
- dot_cfg_ctrl  output  32  engine regs[3]: [15:0] lines per sample, [16] read_from_modelforward, [17] label subtraction
- dot_cfg_offs  output  32  engine regs[4]: [15:0] model offset, [31:16] label offset
- dot_done  input  1  engine completion pulse (one result written)
- result_consumed  input  1  one-cycle pulse; one entry popped from the result FIFO
- busy  output  1  high whenever state is not IDLE
- samples_done  output  16  samples completed in current/last minibatch

Behaviour:
- Reset values:
  - op_done=0, dot_start=0, busy=0, samples_done=0.
  - dot_cfg_ctrl=0, dot_cfg_offs=0.
  - state=IDLE, credits=DOT_FIFO_DEPTH.
  - Reset mid-operation aborts the sequence; the engine is not notified.
- All outputs are registered. The credits counter is clog2(DOT_FIFO_DEPTH+1) bits wide.
- Latched on op_start in IDLE:
  - ctrl=regs[3]
  - base offsets=regs[4]
  - num_samples=regs[5][15:0]
  - label_stride=regs[6][15:0]
  - model_stride=regs[6][31:16]
  - samples_done cleared to 0.
- op_start is ignored when not in IDLE.
- States:
  - IDLE: on op_start go to ISSUE. If num_samples==0, go to DONE instead.
  - ISSUE: if credits!=0, pulse dot_start (visible the next cycle), drive dot_cfg_ctrl/offs with the current offsets, decrement credits, go to WAIT. Otherwise stall in ISSUE.
  - WAIT: on dot_done, increment samples_done, model_off+=model_stride, label_off+=label_stride (16-bit wrap-around, no saturation). If samples_done+1==num_samples go to DONE, else go to ISSUE.
  - DONE: op_done=1 for exactly one cycle, then IDLE.
- Latency:
  - first dot_start rises 2 cycles after op_start is sampled, given credits are available;
  - next dot_start rises 2 cycles after dot_done;
  - op_done rises 2 cycles after the final dot_done.
- dot_cfg_ctrl/offs are stable from the dot_start cycle until the next ISSUE.
- Credits:
  - result_consumed adds 1; an issue in ISSUE subtracts 1; both in the same cycle leave credits unchanged.
  - result_consumed while credits==DOT_FIFO_DEPTH is ignored (saturate).
  - result_consumed is counted in every state, including IDLE.
- dot_done outside WAIT is ignored.

Optional Feature:
- GLM_DOT_SEQ_PERF_EN defined: adds outputs stall_cycles [31:0] and active_cycles [31:0].
  - Both clear on accepted op_start.
  - active_cycles counts every cycle with busy=1.
  - stall_cycles counts ISSUE cycles with credits==0.
  - Both hold their value after DONE; reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package glm_dot_seq_pkg holds:
  - the t_seqstate enum (IDLE, ISSUE, WAIT, DONE);
  - register field constants: CTRL_REG=3, OFFS_REG=4, COUNT_REG=5, STRIDE_REG=6, FORWARD_BIT=16, SUBTRACT_BIT=17.
- One sub-module, glm_credit_counter:
  - parameter DEPTH;
  - inputs take, give; output has_credit;
  - implements the saturating credit logic.

Test Plan:
- regs3=0x00000004, regs4=0x00200010, regs5=3, regs6=0x00010002; engine returns dot_done 10 cycles after each dot_start -> 3 dot_start pulses with dot_cfg_offs 0x00200010, 0x00220011, 0x00240012; samples_done=3; op_done exactly 2 cycles after the third dot_done.
- regs5=0 -> no dot_start; op_done 2 cycles after op_start; busy high for exactly 2 cycles.
- DOT_FIFO_DEPTH=2, num_samples=4, no result_consumed -> exactly 2 dot_start then stall in ISSUE; a result_consumed pulse -> third dot_start 2 cycles later.
- result_consumed coincident with an issue at credits=1 -> credits stay 1 and the next sample issues without stalling.
- Reset asserted in WAIT, then op_start with num_samples=1 -> clean restart; samples_done=0 after reset; credits=DOT_FIFO_DEPTH; single dot_start with fresh offsets.
- Extra op_start and spurious dot_done during IDLE/ISSUE -> ignored; sample count and offsets unchanged.
